// File: rtl/gearbox_rx.sv
// gearbox_rx: 80:67 receive gearbox for an Interlaken lane.
// Bit-offset window over two input words, aligned by a sync-header lock FSM.
`timescale 1ns/1ps
module gearbox_rx #(
  parameter int LOCK_CNT = 64,
  parameter int ERR_WIN  = 64,
  parameter int ERR_MAX  = 16
) (
  input  logic        USER_CLK,
  input  logic        RESET,
  input  logic [79:0] DATA_IN,
  output logic [66:0] DATA_OUT,
  output logic        DATA_VALID,
  output logic        WORD_LOCK,
  output logic        HDR_ERR,
  output logic [6:0]  OFFSET,
  output logic [7:0]  LOCK_LOSS_CNT
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_WIN + 1);
  localparam int BW = $clog2(ERR_MAX + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [79:0]   d_q, d_qq;
  logic [159:0]  win;
  logic [7:0]    idx;
  logic [66:0]   w;
  logic          hdr_ok;
  logic [GW-1:0] good_q, good_d;
  logic [EW-1:0] hdr_q, hdr_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [6:0]    off_q, off_d, slip;
  logic [7:0]    loss_q, loss_d;
  logic [66:0]   dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;

  // Older word in the low half so the window walks the bit stream upward.
  assign win    = {d_q, d_qq};
  assign idx    = {1'b0, off_q};
  assign w      = win[idx +: 67];
  assign hdr_ok = w[65] ^ w[64];
  assign slip   = (off_q == 7'd79) ? 7'd0 : off_q + 7'd1;

  // State, counters, input pipeline and registered outputs.
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state_q <= HUNT;
      d_q     <= '0;
      d_qq    <= '0;
      good_q  <= '0;
      hdr_q   <= '0;
      bad_q   <= '0;
      off_q   <= '0;
      loss_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= DATA_IN;
      d_qq    <= d_q;
      good_q  <= good_d;
      hdr_q   <= hdr_d;
      bad_q   <= bad_d;
      off_q   <= off_d;
      loss_q  <= loss_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  // Lock FSM: next state, counters and bit-slip offset.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    hdr_d   = hdr_q;
    bad_d   = bad_q;
    off_d   = off_q;
    loss_d  = loss_q;
    unique case (state_q)
      HUNT: begin
        if (hdr_ok) begin
          if (good_q == GW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            hdr_d   = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end else begin
          good_d = '0;
          off_d  = slip;
        end
      end
      LOCKED: begin
        if (!hdr_ok && bad_q == BW'(ERR_MAX - 1)) begin
          state_d = HUNT;
          good_d  = '0;
          hdr_d   = '0;
          bad_d   = '0;
          off_d   = slip;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (hdr_q == EW'(ERR_WIN - 1)) begin
          hdr_d = '0;
          bad_d = '0;
        end else begin
          hdr_d = hdr_q + EW'(1);
          if (!hdr_ok) bad_d = bad_q + BW'(1);
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // Output values registered from the header just checked.
  always_comb begin
    dout_d = w;
    err_d  = !hdr_ok;
    lock_d = (state_d == LOCKED);
    vld_d  = lock_d && hdr_ok;
  end

  assign DATA_OUT      = dout_q;
  assign DATA_VALID    = vld_q;
  assign WORD_LOCK     = lock_q;
  assign HDR_ERR       = err_q;
  assign OFFSET        = off_q;
  assign LOCK_LOSS_CNT = loss_q;

endmodule

// File: doc/gearbox_rx.md
# gearbox_rx

Receive-side 80:67 gearbox for the Interlaken lane. Takes the 80-bit parallel word from the transceiver RX datapath and finds the 67-bit block boundary: a bit-offset window over two consecutive input words, driven by a sync-header word-lock state machine. Delivers aligned 67-bit blocks (3-bit header + 64-bit payload) to the RX descrambler/framing logic. Counterpart of the transmit gearbox, which places each 67-bit block in bits [66:0] of an 80-bit word with 13 zero pad bits.

## Interface
Parameters:
- LOCK_CNT, 64: consecutive valid sync headers required to declare lock.
- ERR_WIN, 64: headers per error-monitoring window while locked.
- ERR_MAX, 16: invalid headers within one window that force loss of lock.

Ports:
- USER_CLK  input  1  sole clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  80  raw word from transceiver, sampled every cycle.
- DATA_OUT  output  67  aligned block; [66] inversion bit, [65:64] sync header, [63:0] payload.
- DATA_VALID  output  1  DATA_OUT is a locked block with a valid header.
- WORD_LOCK  output  1  block alignment achieved.
- HDR_ERR  output  1  one-cycle pulse: header of the current DATA_OUT block invalid.
- OFFSET  output  7  current window bit offset, 0..79.
- LOCK_LOSS_CNT  output  8  saturating count of LOCKED->HUNT transitions.

## Operation
- Input pipeline: d_q <= DATA_IN; d_qq <= d_q every cycle. Window buffer buf[159:0] = {d_q, d_qq}; candidate block W = buf[OFFSET +: 67] (max index 145).
- Header check on W: valid iff W[65:64] is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid. Bit 66 is not checked.
- FSM states HUNT, LOCKED. Counters: good_cnt (0..LOCK_CNT), hdr_cnt (0..ERR_WIN), bad_cnt (0..ERR_MAX).
- HUNT, valid header: good_cnt+1; when good_cnt reaches LOCK_CNT on this header -> LOCKED, all counters cleared.
- HUNT, invalid header: good_cnt <= 0; OFFSET <= (OFFSET==79) ? 0 : OFFSET+1 (slip one bit). The new offset applies to the next cycle's window; no blanking cycles.
- LOCKED: every header increments hdr_cnt; invalid ones also increment bad_cnt.
- LOCKED, bad_cnt reaches ERR_MAX -> HUNT, OFFSET slips by one (same wrap rule), all counters cleared, LOCK_LOSS_CNT+1 (holds at 255). This takes priority over window end on the same header.
- LOCKED, hdr_cnt reaches ERR_WIN with bad_cnt < ERR_MAX: hdr_cnt and bad_cnt cleared; stays LOCKED.
- OFFSET never changes while LOCKED.
- Registered outputs, updated each edge from the header just checked:
  - DATA_OUT <= W.
  - HDR_ERR <= header invalid, in any state.
  - WORD_LOCK <= (next state == LOCKED).
  - DATA_VALID <= (next state == LOCKED) && header valid.
- RESET has priority over everything: state HUNT, counters 0, d_q/d_qq 0, OFFSET 0, DATA_OUT 0, DATA_VALID 0, WORD_LOCK 0, HDR_ERR 0, LOCK_LOSS_CNT 0. Reset mid-lock drops lock immediately and restarts the search at offset 0.

## Timing
- Latency at any fixed OFFSET: a block whose bits sit in the word sampled at edge k appears on DATA_OUT after edge k+2. For OFFSET + 66 ≥ 80, the block spans two input words; the later word sets the timing.
- Lock acquisition: WORD_LOCK rises on the edge that registers the LOCK_CNT-th consecutive valid header; that same block is the first with DATA_VALID = 1.
- Lock loss: WORD_LOCK and DATA_VALID fall on the edge that registers the ERR_MAX-th bad header; OFFSET changes on that same edge.
- Throughput: one 67-bit block per cycle, no backpressure. The 13 pad bits per word are discarded.
- Worst-case acquisition from reset with a clean stream: at most 80 slips plus LOCK_CNT, i.e. ≤ 80 + 64 + 2 cycles.

## Test plan
- Reset: hold RESET 3 cycles with random DATA_IN -> all outputs 0 and OFFSET 0. Release -> no output X, WORD_LOCK still 0.
- Aligned stream: transmit-format words {13'b0, 3'b001 or 3'b010 header, random payload} -> OFFSET stays 0. WORD_LOCK rises after exactly 64 headers. DATA_OUT equals each DATA_IN[66:0] three edges later. HDR_ERR never pulses.
- Misaligned stream: same bit stream delayed by 37 bits -> OFFSET slips to 37 and holds. WORD_LOCK follows 64 headers after the last slip. Also run with a delay of 79 -> reaches 79. After forced loss at 79, OFFSET wraps to 0.
- Lock tolerance: once locked, corrupt 15 headers (to 2'b11) within one 64-header window -> WORD_LOCK stays 1. HDR_ERR pulses 15 times; DATA_VALID is 0 exactly on those blocks. Repeat over the next window -> still locked.
- Lock loss: once locked, corrupt 16 headers within one window -> WORD_LOCK falls on the 16th. OFFSET goes 0->1, LOCK_LOSS_CNT=1. Force 300 losses -> LOCK_LOSS_CNT saturates at 255.
- Reset mid-operation: assert RESET while locked at OFFSET=37 -> next edge WORD_LOCK=0 and OFFSET=0; the search restarts and relocks at 37.
